// File: rtl/fifo_pack_rd.sv
// fifo_pack_rd: drains a memory FIFO head and packs PACK words into one wide
// beat on a registered valid/ready stream, counting accepted beats.
// Optional: define FIFO_PACK_FLUSH_EN to add flush/out_keep for partial beats.
module fifo_pack_rd #(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned PACK   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
`ifdef FIFO_PACK_FLUSH_EN
  input  logic                     flush,
  output logic [PACK-1:0]          out_keep,
`endif
  input  logic [DWIDTH-1:0]        fifo_rd,
  input  logic                     fifo_empty,
  output logic                     fifo_rden,
  output logic [DWIDTH*PACK-1:0]   out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [15:0]              beat_cnt
);

  localparam int unsigned CW    = $clog2(PACK);
  localparam int unsigned OW    = DWIDTH * PACK;
  localparam int unsigned NSLOT = PACK - 1;
  localparam int unsigned AW    = NSLOT * DWIDTH;
  localparam logic [CW-1:0] LAST = CW'(PACK - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] asm_q, asm_d;
  logic [OW-1:0] data_d;
  logic          valid_d;
  logic [15:0]   beat_d;
  logic          load_ok;
  logic          last;
  logic          flush_hold;
  logic          flush_load;

  assign load_ok = !out_valid || out_ready;
  assign last    = (cnt_q == LAST);

`ifdef FIFO_PACK_FLUSH_EN
  logic [PACK-1:0] keep_d;
  logic [OW-1:0]   part_beat;
  logic [PACK-1:0] part_keep;

  assign flush_hold = flush;
  assign flush_load = flush && (cnt_q != '0) && load_ok;

  // Partial beat: only the words collected so far, upper words zeroed
  always_comb begin
    part_beat = '0;
    part_keep = '0;
    for (int unsigned i = 0; i < NSLOT; i++) begin
      if (CW'(i) < cnt_q) begin
        part_beat[i*DWIDTH +: DWIDTH] = asm_q[i*DWIDTH +: DWIDTH];
        part_keep[i]                  = 1'b1;
      end
    end
  end
`else
  assign flush_hold = 1'b0;
  assign flush_load = 1'b0;
`endif

  // Pop whenever a word is available and it can be stored or completes a loadable beat
  assign fifo_rden = !rst && !fifo_empty && !flush_hold && (!last || load_ok);

  // Next-state for assembly, output beat and accepted-beat counter
  always_comb begin
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    data_d  = out_data;
    valid_d = out_valid;
    beat_d  = beat_cnt;
`ifdef FIFO_PACK_FLUSH_EN
    keep_d  = out_keep;
`endif
    if (out_valid && out_ready) begin
      valid_d = 1'b0;
      beat_d  = beat_cnt + 16'd1;
    end
    if (fifo_rden) begin
      if (last) begin
        cnt_d   = '0;
        data_d  = {fifo_rd, asm_q};
        valid_d = 1'b1;
`ifdef FIFO_PACK_FLUSH_EN
        keep_d  = '1;
`endif
      end else begin
        cnt_d = cnt_q + CW'(1);
        for (int unsigned i = 0; i < NSLOT; i++) begin
          if (cnt_q == CW'(i)) asm_d[i*DWIDTH +: DWIDTH] = fifo_rd;
        end
      end
    end else if (flush_load) begin
      cnt_d   = '0;
      valid_d = 1'b1;
`ifdef FIFO_PACK_FLUSH_EN
      data_d  = part_beat;
      keep_d  = part_keep;
`endif
    end
  end

  // State and output registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      asm_q     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      beat_cnt  <= '0;
    end else begin
      cnt_q     <= cnt_d;
      asm_q     <= asm_d;
      out_data  <= data_d;
      out_valid <= valid_d;
      beat_cnt  <= beat_d;
    end
  end

`ifdef FIFO_PACK_FLUSH_EN
  // Keep mask travels with out_data
  always_ff @(posedge clk) begin
    if (rst) out_keep <= '0;
    else     out_keep <= keep_d;
  end
`endif

endmodule

// File: tb/tb_fifo_pack_rd.sv
// tb_fifo_pack_rd: queue-based FIFO/packing model with a decoupled monitor.
module tb_fifo_pack_rd;

  localparam int unsigned DW = 8;
  localparam int unsigned PK = 4;
  localparam int unsigned OW = DW * PK;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] fifo_rd;
  logic          fifo_empty;
  logic          fifo_rden;
  logic [OW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   beat_cnt;
  logic          flush;
`ifdef FIFO_PACK_FLUSH_EN
  logic [PK-1:0] out_keep;
`endif

  always #5 clk = ~clk;

  fifo_pack_rd #(.DWIDTH(DW), .PACK(PK)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef FIFO_PACK_FLUSH_EN
    .flush     (flush),
    .out_keep  (out_keep),
`endif
    .fifo_rd   (fifo_rd),
    .fifo_empty(fifo_empty),
    .fifo_rden (fifo_rden),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .beat_cnt  (beat_cnt)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] fifo_q[$];  // words sitting in the upstream FIFO
  logic [DW-1:0] part[$];    // words popped but not yet forming a beat
  logic [OW-1:0] exp_d[$];   // beats produced, awaiting acceptance
  logic [PK-1:0] exp_k[$];
  int            model_beats = 0;
  bit            started = 1'b0;
  bit            gate = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    fifo_q.push_back(w);
  endtask

  // Collected words become one beat; first word in the low bits
  task automatic emit();
    logic [OW-1:0] d;
    d = '0;
    for (int i = 0; i < part.size(); i++) d[i*DW +: DW] = part[i];
    exp_d.push_back(d);
    exp_k.push_back(PK'((1 << part.size()) - 1));
    part.delete();
  endtask

  // One clock: present FIFO head, predict pop, advance model after the edge
  task automatic step(output bit popped);
    bit   do_pop;
    bit   do_flush;
    bit   lok;
    logic exp_rden;
    fifo_empty = gate || (fifo_q.size() == 0);
    fifo_rd    = fifo_empty ? DW'($urandom) : fifo_q[0];
    #1;
    lok      = (exp_d.size() == 0) || out_ready;
    exp_rden = !rst && !fifo_empty && !flush && ((part.size() < PK - 1) || lok);
    if (started) check("fifo_rden", 64'(fifo_rden), 64'(exp_rden));
    do_pop   = fifo_rden && !fifo_empty && !rst;
    do_flush = flush && !rst && (part.size() > 0) && lok;
    popped   = do_pop;
    @(posedge clk);
    #1;
    if (rst) begin
      part.delete();
      exp_d.delete();
      exp_k.delete();
    end else if (do_pop) begin
      part.push_back(fifo_q.pop_front());
      if (part.size() == PK) emit();
    end else if (do_flush) begin
      emit();
    end
    @(negedge clk);
  endtask

  // Monitor: checks stream outputs each cycle and scores accepted beats
  initial begin
    bit            stall_prev;
    logic [OW-1:0] hold_data;
    logic [OW-1:0] ed;
    logic [PK-1:0] ek;
    stall_prev = 1'b0;
    hold_data  = '0;
    forever begin
      @(negedge clk);
      #2;
      if (started) begin
        check("beat_cnt", 64'(beat_cnt), 64'(16'(model_beats)));
        check("out_valid", 64'(out_valid), 64'(exp_d.size() != 0));
        if (stall_prev) check("hold_data", 64'(out_data), 64'(hold_data));
        if (out_valid && out_ready && !rst) begin
          if (exp_d.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got %h expected none", out_data);
          end else begin
            ed = exp_d.pop_front();
            ek = exp_k.pop_front();
            check("out_data", 64'(out_data), 64'(ed));
`ifdef FIFO_PACK_FLUSH_EN
            check("out_keep", 64'(out_keep), 64'(ek));
`endif
            model_beats++;
          end
        end
        stall_prev = out_valid && !out_ready && !rst;
        hold_data  = out_data;
        if (rst) model_beats = 0;
      end
    end
  end

  // Stimulus
  initial begin
    bit p;
    int n;
    rst = 1'b1; out_ready = 1'b1; flush = 1'b0; fifo_empty = 1'b1; fifo_rd = '0;
    @(negedge clk);
    step(p);
    step(p);
    check("rst_data", 64'(out_data), 64'(0));
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_beat", 64'(beat_cnt), 64'(0));
    started = 1'b1;
    rst = 1'b0;

    // single group
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    n = 0;
    repeat (6) begin step(p); n += int'(p); end
    check("t1_pops", 64'(n), 64'(4));
    check("t1_beats", 64'(beat_cnt), 64'(1));

    // continuous stream of 12 words
    for (int i = 0; i < 12; i++) push(DW'($urandom));
    n = 0;
    repeat (12) begin step(p); n += int'(p); end
    check("t2_pops", 64'(n), 64'(12));
    repeat (3) step(p);
    check("t2_beats", 64'(beat_cnt), 64'(4));

    // back-pressure
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(DW'($urandom));
    n = 0;
    repeat (10) begin step(p); n += int'(p); end
    check("t3_stall_pops", 64'(n), 64'(7));
    out_ready = 1'b1;
    step(p);
    check("t3_resume", 64'(p), 64'(1));
    repeat (3) step(p);
    check("t3_beats", 64'(beat_cnt), 64'(6));

    // empty flag toggling
    for (int i = 0; i < 16; i++) push(DW'($urandom));
    repeat (40) begin gate = ~gate; step(p); end
    gate = 1'b0;
    repeat (4) step(p);
    check("t4_beats", 64'(beat_cnt), 64'(10));

    // reset mid-group
    push(8'h5A); push(8'h5B);
    repeat (2) step(p);
    rst = 1'b1;
    step(p);
    rst = 1'b0;
    push(8'hA0); push(8'hA1); push(8'hA2); push(8'hA3);
    repeat (6) step(p);
    check("t5_beats", 64'(beat_cnt), 64'(1));

    // random traffic
    repeat (3000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      gate      = ($urandom_range(0, 3) == 0);
      rst       = ($urandom_range(0, 299) == 0);
      if (fifo_q.size() < 20 && $urandom_range(0, 2) != 0) push(DW'($urandom));
      step(p);
    end
    rst = 1'b0; gate = 1'b0; out_ready = 1'b1;
    repeat (40) step(p);
    check("drain_fifo", 64'(fifo_q.size()), 64'(0));

`ifdef FIFO_PACK_FLUSH_EN
    rst = 1'b1;
    step(p);
    rst = 1'b0;
    push(8'h01); push(8'h02); push(8'h03);
    repeat (3) step(p);
    flush = 1'b1;
    push(8'h04); push(8'h05); push(8'h06); push(8'h07);
    n = 0;
    repeat (3) begin step(p); n += int'(p); end
    check("flush_no_pop", 64'(n), 64'(0));
    flush = 1'b0;
    repeat (8) step(p);
    check("flush_beats", 64'(beat_cnt), 64'(2));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_pack_rd.md
Name: fifo_pack_rd

Overview:
- Read-side drain stage sitting directly downstream of the team's memory-based FIFO.
- Pops DWIDTH-bit words from the FIFO head and packs PACK consecutive words into one wide beat.
- Presents each beat on a registered valid/ready stream for the next accelerator stage.
- Sustains one FIFO pop per cycle when the consumer never stalls.

Parameters:
- DWIDTH, 8, width of one FIFO word.
- PACK, 4, number of FIFO words packed per output beat; legal values are 2 to 16.

Ports:
- clk  input  1  single clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- fifo_rd  input  DWIDTH  FIFO head word; combinational read, valid whenever fifo_empty=0.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rden  output  1  FIFO pop strobe; the head word is consumed at the clock edge where this is 1.
- out_data  output  DWIDTH*PACK  packed beat; the first-popped word occupies bits [DWIDTH-1:0].
- out_valid  output  1  beat valid.
- out_ready  input  1  consumer accepts the beat.
- beat_cnt  output  16  count of accepted output beats (out_valid & out_ready); wraps modulo 2^16.

Behaviour:
- Reset (rst=1 at a clock edge):
  - cnt=0, assembly register=0, out_valid=0, out_data=0, beat_cnt=0.
  - fifo_rden is forced to 0 combinationally while rst=1.
  - Reset mid-group discards all partially assembled words.
  - Reset drops a pending beat even if out_ready=1 in the same cycle, and beat_cnt does not increment.
- Internal state:
  - cnt holds 0 to PACK-1 words.
  - asm is the assembly register for words 0 to PACK-2.
  - cnt never reaches PACK.
- load_ok = !out_valid | out_ready.
- Pop rule: fifo_rden = !fifo_empty & (cnt < PACK-1 | load_ok).
  - fifo_rden must never be 1 while fifo_empty=1.
- Pop with cnt < PACK-1: asm word slot[cnt] <= fifo_rd; cnt <= cnt+1.
- Pop with cnt == PACK-1 (group completes):
  - out_data <= {fifo_rd, asm[PACK-2:0]}; out_valid <= 1; cnt <= 0.
  - The asm contents are don't-care afterwards.
- Latency: the last word of a group, popped at edge N, appears on out_data with out_valid=1 right after edge N (registered, one cycle).
- Handshake:
  - Once out_valid=1, out_data is held stable until the edge where out_ready=1.
  - On acceptance with no new load, out_valid <= 0.
  - On acceptance and a simultaneous group completion, out_valid stays 1 and out_data takes the new beat with no bubble.
- Back-pressure:
  - With out_valid=1 and out_ready=0, the FIFO is popped until cnt=PACK-1, then pops stall.
  - Pops resume in the same cycle out_ready rises.
- Empty FIFO: no pops; state holds indefinitely. Partial groups are never emitted unless the optional feature below is compiled in.
- beat_cnt increments by 1 on every out_valid & out_ready edge; 16'hFFFF wraps to 0.
- Widths: cnt is $clog2(PACK) bits. All counters wrap silently; there are no error outputs.

Optional Feature:
- Macro: FIFO_PACK_FLUSH_EN.
- Defined: adds input flush (1 bit) and output out_keep (PACK bits, one bit per word, bit i covers word i).
  - While flush=1, fifo_rden is forced 0.
  - If cnt>0 and load_ok, a partial beat is loaded: out_data = asm words 0..cnt-1 with upper words zeroed, out_keep = (1<<cnt)-1, out_valid <= 1, cnt <= 0.
  - flush with cnt=0 has no effect.
  - Full beats carry out_keep = all ones.
  - out_keep resets to 0 and is held stable alongside out_data.
- Not defined: neither port exists; behaviour is exactly as in Behaviour above.

Test Plan:
- Reset then FIFO holding 8'h11,22,33,44 with out_ready=1 -> fifo_rden high for 4 cycles; one cycle later out_data=32'h44332211 and out_valid=1 for 1 cycle; beat_cnt=1.
- 12 words streamed continuously with out_ready=1 -> 3 beats on consecutive group boundaries, fifo_rden never drops, beat_cnt=3.
- out_ready=0 with 8 words queued -> beat 1 held stable; exactly 3 more pops then fifo_rden=0; when out_ready=1, pop resumes the same cycle and beat 2 follows with no bubble.
- fifo_empty toggling every cycle -> fifo_rden never asserted while empty; word order in out_data preserved.
- rst asserted after 2 words of a group, then 4 new words 8'hA0..A3 -> those 2 words are discarded; out_data=32'hA3A2A1A0; beat_cnt restarts from 0.
- FIFO_PACK_FLUSH_EN: 3 words 8'h01,02,03 then flush=1 -> out_data=32'h00030201, out_keep=4'b0111, cnt returns to 0; no pops while flush is held.
